// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button conditioning stage.
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } ch_state_e;

  localparam int N_BTN_DEF       = 4;
  localparam int DEBOUNCE_MS_DEF = 10;
  localparam int CNT_W_DEF       = 16;

  // A zero-length window would accept every glitch; treat it as one millisecond.
  function automatic int eff_window(input int ms);
    return (ms < 1) ? 1 : ms;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM and millisecond counter.
// BTN_ACTIVE_LOW_EN selects pull-up pins (0 = pressed); the synchroniser then resets to the idle pin level.
//
// state        | meaning
// RELEASED     | stable released, level 0
// PRESS_PEND   | input went high, waiting for a full window of stable 1
// PRESSED      | stable pressed, level 1
// RELEASE_PEND | input went low, waiting for a full window of stable 0 (level still 1)
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  input  logic ms_tick_i,
  output logic level_o,
  output logic press_o,
  output logic press_d_o
);

  localparam int              WIN     = eff_window(DEBOUNCE_MS);
  localparam int              MS_W    = $clog2(WIN + 1);
  localparam logic [MS_W-1:0] WIN_M1  = MS_W'(WIN - 1);
  localparam logic [MS_W-1:0] CNT_MAX = '1;

`ifdef BTN_ACTIVE_LOW_EN
  localparam logic PIN_IDLE = 1'b1;
`else
  localparam logic PIN_IDLE = 1'b0;
`endif

  logic [1:0]      sync_q;
  logic            pressed;
  ch_state_e       state_q, state_d;
  logic [MS_W-1:0] ms_cnt_q, ms_cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;

  // The synchroniser carries the pin level; XOR with the idle level yields 1 = pressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {2{PIN_IDLE}};
    else     sync_q <= {sync_q[0], raw_i};
  end

  assign pressed = sync_q[1] ^ PIN_IDLE;

  always_comb begin
    state_d  = state_q;
    ms_cnt_d = ms_cnt_q;
    unique case (state_q)
      RELEASED: begin
        if (pressed) begin
          state_d  = PRESS_PEND;
          ms_cnt_d = '0;
        end
      end
      PRESS_PEND: begin
        if (!pressed) begin
          state_d  = RELEASED;
          ms_cnt_d = '0;
        end else if (ms_tick_i) begin
          if (ms_cnt_q >= WIN_M1) begin
            state_d  = PRESSED;
            ms_cnt_d = '0;
          end else if (ms_cnt_q != CNT_MAX) begin
            ms_cnt_d = ms_cnt_q + 1'b1;
          end
        end
      end
      PRESSED: begin
        if (!pressed) begin
          state_d  = RELEASE_PEND;
          ms_cnt_d = '0;
        end
      end
      RELEASE_PEND: begin
        if (pressed) begin
          state_d  = PRESSED;
          ms_cnt_d = '0;
        end else if (ms_tick_i) begin
          if (ms_cnt_q >= WIN_M1) begin
            state_d  = RELEASED;
            ms_cnt_d = '0;
          end else if (ms_cnt_q != CNT_MAX) begin
            ms_cnt_d = ms_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d  = RELEASED;
        ms_cnt_d = '0;
      end
    endcase
  end

  // Level is registered from the next state so it changes on the same edge as the FSM.
  assign level_d = (state_d == PRESSED) || (state_d == RELEASE_PEND);
  assign press_d = level_d & ~level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RELEASED;
      ms_cnt_q <= '0;
      level_q  <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ms_cnt_q <= ms_cnt_d;
      level_q  <= level_d;
      press_q  <= press_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign press_d_o = press_d;

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioning ahead of the game core: shared ms prescaler plus N_BTN debounce channels.
// Optional BTN_ACTIVE_LOW_EN (handled per channel) supports pull-up pins.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int N_BTN       = N_BTN_DEF,
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] ticks_per_milli,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic             any_press
);

  logic [CNT_W-1:0] presc_q, presc_d;
  logic             ms_tick;
  logic [N_BTN-1:0] press_d;
  logic             any_q;

  // >= rather than == so lowering ticks_per_milli below the count wraps at once.
  always_comb begin
    ms_tick = (ticks_per_milli <= CNT_W'(1)) || (presc_q >= (ticks_per_milli - CNT_W'(1)));
    presc_d = ms_tick ? '0 : presc_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      any_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      any_q   <= |press_d;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_MS(DEBOUNCE_MS)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .raw_i     (btn_raw[g]),
      .ms_tick_i (ms_tick),
      .level_o   (btn_level[g]),
      .press_o   (btn_press[g]),
      .press_d_o (press_d[g])
    );
  end

  assign any_press = any_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: press/release latency, bounce rejection, reset and prescaler corners.
module tb_btn_debounce;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ticks_per_milli = 16'd50;
  logic [3:0]  btn_raw = 4'b0000;
  logic [3:0]  btn_level;
  logic [3:0]  btn_press;
  logic        any_press;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_pops   = 0;
  logic [3:0]  sb_q[$];

  btn_debounce dut (
    .clk             (clk),
    .rst             (rst),
    .ticks_per_milli (ticks_per_milli),
    .btn_raw         (btn_raw),
    .btn_level       (btn_level),
    .btn_press       (btn_press),
    .any_press       (any_press)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe seen on the outputs must match the next expected mask.
  always @(negedge clk) begin
    logic [3:0] exp_mask;
    if (!rst && (btn_press !== 4'b0000 || any_press !== 1'b0)) begin
      exp_mask = (sb_q.size() > 0) ? sb_q.pop_front() : 4'b0000;
      n_pops++;
      check("press_mask", 32'(btn_press), 32'(exp_mask));
      check("any_press", 32'(any_press), 32'(exp_mask != 4'b0000));
    end
  end

  task automatic wait_level(input int idx, input logic val, input int max_cyc, output int cyc);
    cyc = 0;
    while (btn_level[idx] !== val && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int  cyc;
    bit  seen;
    logic [3:0] pat;

    // Reset and idle
    repeat (5) @(negedge clk);
    check("rst_level", 32'(btn_level), 0);
    check("rst_press", 32'(btn_press), 0);
    check("rst_any", 32'(any_press), 0);
    rst = 1'b0;
    repeat (2000) @(negedge clk);
    check("idle_level", 32'(btn_level), 0);
    check("idle_strobes", 32'(n_pops), 0);

    // Clean press on channel 0
    sb_q.push_back(4'b0001);
    btn_raw = 4'b0001;
    wait_level(0, 1'b1, 600, cyc);
    check("press0_latency_in_window", 32'(cyc >= 452 && cyc <= 503), 1);
    check("press0_strobe", 32'(btn_press), 32'(4'b0001));
    check("press0_any", 32'(any_press), 1);
    @(negedge clk);
    check("press0_strobe_one_cycle", 32'(btn_press), 0);
    check("press0_any_one_cycle", 32'(any_press), 0);

    // Clean release on channel 0
    btn_raw = 4'b0000;
    wait_level(0, 1'b0, 600, cyc);
    check("release0_latency_in_window", 32'(cyc >= 452 && cyc <= 503), 1);

    // Bounce reject on channel 2
    seen = 1'b0;
    for (int t = 0; t < 10; t++) begin
      btn_raw[2] = ~btn_raw[2];
      repeat (100) begin
        @(negedge clk);
        if (btn_level[2] !== 1'b0) seen = 1'b1;
      end
    end
    repeat (600) begin
      @(negedge clk);
      if (btn_level[2] !== 1'b0) seen = 1'b1;
    end
    check("bounce2_level_quiet", 32'(seen), 0);
    check("bounce2_no_strobe", 32'(n_pops), 1);

    // Release with bounce on channel 1
    sb_q.push_back(4'b0010);
    btn_raw = 4'b0010;
    wait_level(1, 1'b1, 600, cyc);
    check("press1_latency_in_window", 32'(cyc >= 452 && cyc <= 503), 1);
    repeat (100) @(negedge clk);
    seen = 1'b0;
    for (int p = 0; p < 3; p++) begin
      btn_raw[1] = 1'b0;
      repeat (30) begin @(negedge clk); if (btn_level[1] !== 1'b1) seen = 1'b1; end
      btn_raw[1] = 1'b1;
      repeat (30) begin @(negedge clk); if (btn_level[1] !== 1'b1) seen = 1'b1; end
    end
    btn_raw[1] = 1'b0;
    check("bounce1_level_held", 32'(seen), 0);
    wait_level(1, 1'b0, 600, cyc);
    check("release1_latency_in_window", 32'(cyc >= 452 && cyc <= 503), 1);
    check("release1_single_strobe", 32'(n_pops), 2);

    // Simultaneous press on channels 0 and 3
    sb_q.push_back(4'b1001);
    btn_raw = 4'b1001;
    wait_level(0, 1'b1, 600, cyc);
    check("simul_latency_in_window", 32'(cyc >= 452 && cyc <= 503), 1);
    check("simul_level", 32'(btn_level), 32'(4'b1001));
    btn_raw = 4'b0000;
    repeat (600) @(negedge clk);
    check("simul_released", 32'(btn_level), 0);

    // Reset in the middle of a press window
    btn_raw = 4'b1001;
    repeat (250) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_level", 32'(btn_level), 0);
    @(negedge clk);
    rst = 1'b0;
    sb_q.push_back(4'b1001);
    wait_level(3, 1'b1, 700, cyc);
    check("midrst_fresh_window", 32'(cyc >= 452 && cyc <= 503), 1);
    check("midrst_level_after", 32'(btn_level), 32'(4'b1001));
    btn_raw = 4'b0000;
    repeat (600) @(negedge clk);

    // ticks_per_milli of 0 and 1: one ms per cycle
    for (int k = 0; k < 2; k++) begin
      ticks_per_milli = 16'(k);
      sb_q.push_back(4'b1000);
      btn_raw = 4'b1000;
      wait_level(3, 1'b1, 100, cyc);
      check("fast_tick_press_latency", 32'(cyc >= 10 && cyc <= 16), 1);
      btn_raw = 4'b0000;
      wait_level(3, 1'b0, 100, cyc);
      check("fast_tick_release_latency", 32'(cyc >= 10 && cyc <= 16), 1);
    end

    // Lowering ticks_per_milli below the running count
    ticks_per_milli = 16'd50;
    repeat (3) @(negedge clk);
    cyc = 0;
    while (dut.ms_tick !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    check("presc_tick_found", 32'(cyc < 100), 1);
    repeat (30) @(negedge clk);
    check("presc_mid_count_quiet", 32'(dut.ms_tick), 0);
    ticks_per_milli = 16'd5;
    #1;
    check("presc_tick_on_lower", 32'(dut.ms_tick), 1);
    @(negedge clk);
    cyc = 1;
    while (dut.ms_tick !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    check("presc_new_period", 32'(cyc), 5);

    repeat (20) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 0);
    check("strobe_events", 32'(n_pops), 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
